// File: rtl/datapath_ctrl.sv
// Sequencing controller for a register-file + adder datapath.
// Each command goes READ -> EXEC -> WB, which gives one operation every four cycles.
module datapath_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] rf_ra1,
    output logic [ADDR_W-1:0] rf_ra2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    output logic              add_cin,
    input  logic [DATA_W-1:0] add_sum,
    input  logic              add_cout,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              cout_flag,
    output logic [15:0]       op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADDI = 2'b10;
    localparam logic [1:0] OP_LDI  = 2'b11;

    state_t              state_r;
    state_t              state_next_s;
    logic                handshake_s;

    // Latched command fields; rs1/rs2 drive the read ports directly so
    // the addresses are stable from the handshake edge onwards.
    logic [1:0]          op_r;
    logic [ADDR_W-1:0]   rd_r;
    logic [ADDR_W-1:0]   rs1_r;
    logic [ADDR_W-1:0]   rs2_r;
    logic [DATA_W-1:0]   imm_r;

    logic                cmd_ready_r;
    logic                rf_we_r;
    logic                done_r;
    logic [ADDR_W-1:0]   rf_wa_r;
    logic [DATA_W-1:0]   rf_wd_r;
    logic                carry_r;
    logic [DATA_W-1:0]   add_a_r;
    logic [DATA_W-1:0]   add_b_r;
    logic                add_cin_r;
    logic [DATA_W-1:0]   result_r;
    logic                cout_flag_r;
    logic [15:0]         op_count_r;

    logic [DATA_W-1:0]   add_a_next_s;
    logic [DATA_W-1:0]   add_b_next_s;
    logic                add_cin_next_s;

    assign handshake_s = cmd_valid & cmd_ready_r;

    // Next-state decode: only IDLE waits, the rest of the sequence is fixed.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (handshake_s) begin
                    state_next_s = ST_READ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ: state_next_s = ST_EXEC;
            ST_EXEC: state_next_s = ST_WB;
            ST_WB:   state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Adder operand select, registered at the READ->EXEC edge so the operands
    // (opA/opB as read from the register file) are presented throughout EXEC.
    always_comb begin
        add_a_next_s   = {DATA_W{1'b0}};
        add_b_next_s   = {DATA_W{1'b0}};
        add_cin_next_s = 1'b0;
        if (state_r == ST_READ) begin
            case (op_r)
                OP_ADD: begin
                    add_a_next_s = rf_rd1;
                    add_b_next_s = rf_rd2;
                end
                OP_SUB: begin
                    add_a_next_s   = rf_rd1;
                    add_b_next_s   = ~rf_rd2;
                    add_cin_next_s = 1'b1;
                end
                OP_ADDI: begin
                    add_a_next_s = rf_rd1;
                    add_b_next_s = imm_r;
                end
                OP_LDI: begin
                    add_b_next_s = imm_r;
                end
                default: begin
                    add_a_next_s   = {DATA_W{1'b0}};
                    add_b_next_s   = {DATA_W{1'b0}};
                    add_cin_next_s = 1'b0;
                end
            endcase
        end else begin
            add_a_next_s   = {DATA_W{1'b0}};
            add_b_next_s   = {DATA_W{1'b0}};
            add_cin_next_s = 1'b0;
        end
    end

    // State register, command latch and all registered outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b1;
            op_r        <= 2'b00;
            rd_r        <= {ADDR_W{1'b0}};
            rs1_r       <= {ADDR_W{1'b0}};
            rs2_r       <= {ADDR_W{1'b0}};
            imm_r       <= {DATA_W{1'b0}};
            rf_we_r     <= 1'b0;
            done_r      <= 1'b0;
            rf_wa_r     <= {ADDR_W{1'b0}};
            rf_wd_r     <= {DATA_W{1'b0}};
            carry_r     <= 1'b0;
            add_a_r     <= {DATA_W{1'b0}};
            add_b_r     <= {DATA_W{1'b0}};
            add_cin_r   <= 1'b0;
            result_r    <= {DATA_W{1'b0}};
            cout_flag_r <= 1'b0;
            op_count_r  <= 16'h0000;
        end else begin
            state_r     <= state_next_s;
            cmd_ready_r <= (state_next_s == ST_IDLE);
            add_a_r     <= add_a_next_s;
            add_b_r     <= add_b_next_s;
            add_cin_r   <= add_cin_next_s;
            rf_we_r     <= (state_r == ST_EXEC);
            done_r      <= (state_r == ST_EXEC);

            if (handshake_s) begin
                op_r  <= cmd_op;
                rd_r  <= cmd_rd;
                rs1_r <= cmd_rs1;
                rs2_r <= cmd_rs2;
                imm_r <= cmd_imm;
            end else begin
                op_r  <= op_r;
                rd_r  <= rd_r;
                rs1_r <= rs1_r;
                rs2_r <= rs2_r;
                imm_r <= imm_r;
            end

            // The write-port data register doubles as the captured sum.
            if (state_r == ST_EXEC) begin
                rf_wa_r <= rd_r;
                rf_wd_r <= add_sum;
                carry_r <= add_cout;
            end else begin
                rf_wa_r <= rf_wa_r;
                rf_wd_r <= rf_wd_r;
                carry_r <= carry_r;
            end

            if (state_r == ST_WB) begin
                result_r    <= rf_wd_r;
                cout_flag_r <= carry_r;
                op_count_r  <= op_count_r + 16'h0001;
            end else begin
                result_r    <= result_r;
                cout_flag_r <= cout_flag_r;
                op_count_r  <= op_count_r;
            end
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign rf_ra1    = rs1_r;
    assign rf_ra2    = rs2_r;
    assign rf_we     = rf_we_r;
    assign rf_wa     = rf_wa_r;
    assign rf_wd     = rf_wd_r;
    assign add_a     = add_a_r;
    assign add_b     = add_b_r;
    assign add_cin   = add_cin_r;
    assign done      = done_r;
    assign result    = result_r;
    assign cout_flag = cout_flag_r;
    assign op_count  = op_count_r;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed self-checking bench for datapath_ctrl with a behavioural
// register file and adder attached to its datapath ports.
module tb_datapath_ctrl;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_rd;
    logic [3:0]  cmd_rs1;
    logic [3:0]  cmd_rs2;
    logic [31:0] cmd_imm;
    logic [3:0]  rf_ra1;
    logic [3:0]  rf_ra2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;
    logic        done;
    logic [31:0] result;
    logic        cout_flag;
    logic [15:0] op_count;

    logic [31:0] regs [16];
    logic [15:0] exp_cnt;
    int          n_checks;
    int          n_passed;
    int          hs_cnt;
    longint      hs_time [8];
    int          we_cnt;
    int          done_cnt;
    int          base_hs;
    int          snap_we;
    int          snap_done;

    datapath_ctrl dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_rd   (cmd_rd),
        .cmd_rs1  (cmd_rs1),
        .cmd_rs2  (cmd_rs2),
        .cmd_imm  (cmd_imm),
        .rf_ra1   (rf_ra1),
        .rf_ra2   (rf_ra2),
        .rf_rd1   (rf_rd1),
        .rf_rd2   (rf_rd2),
        .rf_we    (rf_we),
        .rf_wa    (rf_wa),
        .rf_wd    (rf_wd),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .done     (done),
        .result   (result),
        .cout_flag(cout_flag),
        .op_count (op_count)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // Behavioural register file and adder
    assign rf_rd1 = regs[rf_ra1];
    assign rf_rd2 = regs[rf_ra2];
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    // Register-file write port plus handshake / pulse monitors
    always @(posedge wb_clk_i) begin
        if (rf_we) regs[rf_wa] <= rf_wd;
        if (rf_we) we_cnt <= we_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (cmd_valid && cmd_ready && !wb_rst_i) begin
            hs_time[hs_cnt[2:0]] <= $time;
            hs_cnt <= hs_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one command from an IDLE negedge and check every stage of it.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                           input logic [3:0] rs2, input logic [31:0] imm,
                           input logic [31:0] ea, input logic [31:0] eb, input logic ecin,
                           input logic [31:0] ewd, input logic ecout);
        check("ready_before", {31'd0, cmd_ready}, 32'd1);
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        cmd_valid = 1'b1;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        check("read_ready", {31'd0, cmd_ready}, 32'd0);
        check("read_ra1", {28'd0, rf_ra1}, {28'd0, rs1});
        check("read_ra2", {28'd0, rf_ra2}, {28'd0, rs2});
        check("read_we", {31'd0, rf_we}, 32'd0);
        @(negedge wb_clk_i);
        check("exec_a", add_a, ea);
        check("exec_b", add_b, eb);
        check("exec_cin", {31'd0, add_cin}, {31'd0, ecin});
        check("exec_done", {31'd0, done}, 32'd0);
        @(negedge wb_clk_i);
        check("wb_we", {31'd0, rf_we}, 32'd1);
        check("wb_done", {31'd0, done}, 32'd1);
        check("wb_wa", {28'd0, rf_wa}, {28'd0, rd});
        check("wb_wd", rf_wd, ewd);
        check("wb_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge wb_clk_i);
        exp_cnt = exp_cnt + 16'd1;
        check("idle_ready", {31'd0, cmd_ready}, 32'd1);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_we", {31'd0, rf_we}, 32'd0);
        check("result", result, ewd);
        check("cout_flag", {31'd0, cout_flag}, {31'd0, ecout});
        check("op_count", {16'd0, op_count}, {16'd0, exp_cnt});
        check("regfile", regs[rd], ewd);
    endtask

    // Wait (bounded) until the handshake counter reaches target.
    task automatic wait_hs(input int target);
        int k;
        k = 0;
        while (hs_cnt < target && k < 20) begin
            @(negedge wb_clk_i);
            k++;
        end
        check("hs_timeout", {31'd0, (hs_cnt >= target)}, 32'd1);
    endtask

    initial begin
        n_checks = 0; n_passed = 0; hs_cnt = 0; we_cnt = 0; done_cnt = 0;
        exp_cnt = 16'd0;
        for (int i = 0; i < 16; i++) regs[i] = 32'd0;
        wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
        cmd_rd = 4'd0; cmd_rs1 = 4'd0; cmd_rs2 = 4'd0; cmd_imm = 32'd0;

        // Reset state
        repeat (2) @(negedge wb_clk_i);
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_add_a", add_a, 32'd0);
        check("rst_ra1", {28'd0, rf_ra1}, 32'd0);
        check("rst_wd", rf_wd, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_cnt", {16'd0, op_count}, 32'd0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        // LDI r3 = 5
        run_cmd(2'b11, 4'd3, 4'd0, 4'd0, 32'h0000_0005, 32'd0, 32'd5, 1'b0, 32'd5, 1'b0);

        // ADD overflow: 0xFFFFFFFF + 1
        run_cmd(2'b11, 4'd1, 4'd0, 4'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_cmd(2'b11, 4'd2, 4'd0, 4'd0, 32'h0000_0001, 32'd0, 32'd1, 1'b0, 32'd1, 1'b0);
        run_cmd(2'b00, 4'd4, 4'd1, 4'd2, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1);

        // SUB with borrow and without
        run_cmd(2'b11, 4'd1, 4'd0, 4'd0, 32'd3, 32'd0, 32'd3, 1'b0, 32'd3, 1'b0);
        run_cmd(2'b11, 4'd2, 4'd0, 4'd0, 32'd5, 32'd0, 32'd5, 1'b0, 32'd5, 1'b0);
        run_cmd(2'b01, 4'd6, 4'd1, 4'd2, 32'd0, 32'd3, 32'hFFFF_FFFA, 1'b1, 32'hFFFF_FFFE, 1'b0);
        run_cmd(2'b01, 4'd6, 4'd2, 4'd1, 32'd0, 32'd5, 32'hFFFF_FFFC, 1'b1, 32'd2, 1'b1);

        // ADDI reads r6 = 2
        run_cmd(2'b10, 4'd7, 4'd6, 4'd0, 32'h10, 32'd2, 32'h10, 1'b0, 32'h12, 1'b0);

        // Register 0 is an ordinary register
        run_cmd(2'b11, 4'd0, 4'd0, 4'd0, 32'h55, 32'd0, 32'h55, 1'b0, 32'h55, 1'b0);
        run_cmd(2'b00, 4'd12, 4'd0, 4'd0, 32'd0, 32'h55, 32'h55, 1'b0, 32'hAA, 1'b0);

        // Back-to-back with cmd_valid held high; fields change while busy
        base_hs = hs_cnt;
        cmd_op = 2'b11; cmd_rd = 4'd8; cmd_rs1 = 4'd0; cmd_rs2 = 4'd0; cmd_imm = 32'h100;
        cmd_valid = 1'b1;
        wait_hs(base_hs + 1);
        cmd_op = 2'b10; cmd_rd = 4'd9; cmd_rs1 = 4'd8; cmd_imm = 32'h1;
        wait_hs(base_hs + 2);
        cmd_op = 2'b10; cmd_rd = 4'd10; cmd_rs1 = 4'd9; cmd_imm = 32'h1;
        wait_hs(base_hs + 3);
        cmd_valid = 1'b0;
        repeat (4) @(negedge wb_clk_i);
        exp_cnt = exp_cnt + 16'd3;
        check("b2b_gap1", 32'(hs_time[(base_hs + 1) % 8] - hs_time[base_hs % 8]), 32'd40);
        check("b2b_gap2", 32'(hs_time[(base_hs + 2) % 8] - hs_time[(base_hs + 1) % 8]), 32'd40);
        check("b2b_r8", regs[8], 32'h100);
        check("b2b_r9", regs[9], 32'h101);
        check("b2b_r10", regs[10], 32'h102);
        check("b2b_cnt", {16'd0, op_count}, {16'd0, exp_cnt});
        check("b2b_result", result, 32'h102);

        // Reset pulsed during EXEC aborts the command
        cmd_op = 2'b11; cmd_rd = 4'd11; cmd_imm = 32'hAB; cmd_valid = 1'b1;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        @(negedge wb_clk_i);
        snap_we = we_cnt; snap_done = done_cnt;
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        exp_cnt = 16'd0;
        check("abort_we", {31'd0, rf_we}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_cnt", {16'd0, op_count}, 32'd0);
        @(negedge wb_clk_i);
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (4) @(negedge wb_clk_i);
        check("abort_no_we", 32'(we_cnt - snap_we), 32'd0);
        check("abort_no_done", 32'(done_cnt - snap_done), 32'd0);
        check("abort_r11", regs[11], 32'd0);

        // Reset wins over a simultaneous handshake
        snap_we = we_cnt;
        cmd_op = 2'b11; cmd_rd = 4'd13; cmd_imm = 32'h77; cmd_valid = 1'b1; wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0; wb_rst_i = 1'b0;
        check("rstpri_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (4) @(negedge wb_clk_i);
        check("rstpri_ready2", {31'd0, cmd_ready}, 32'd1);
        check("rstpri_no_we", 32'(we_cnt - snap_we), 32'd0);
        check("rstpri_r13", regs[13], 32'd0);

        // op_count wraps from 0xFFFF to 0x0000
        force dut.op_count_r = 16'hFFFF;
        @(negedge wb_clk_i);
        release dut.op_count_r;
        @(negedge wb_clk_i);
        exp_cnt = 16'hFFFF;
        check("preload_cnt", {16'd0, op_count}, 32'h0000_FFFF);
        run_cmd(2'b11, 4'd5, 4'd0, 4'd0, 32'h9, 32'd0, 32'h9, 1'b0, 32'h9, 1'b0);
        check("wrap_cnt", {16'd0, op_count}, 32'd0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/datapath_ctrl.md
DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, register-file address width (16 registers).
REQ-002 SHALL have parameter DATA_W, default 32, datapath word width.
REQ-003 SHALL have one clock and a synchronous active-high reset, named wb_clk_i and wb_rst_i as elsewhere in the codebase.
REQ-004 wb_clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 wb_rst_i  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  controller can accept a command.
REQ-008 cmd_op  in  2  operation: 00 ADD, 01 SUB, 10 ADDI, 11 LDI.
REQ-009 cmd_rd / cmd_rs1 / cmd_rs2  in  ADDR_W each  destination and source register indices.
REQ-010 cmd_imm  in  DATA_W  immediate for ADDI and LDI.
REQ-011 rf_ra1 / rf_ra2  out  ADDR_W each  register-file read addresses.
REQ-012 rf_rd1 / rf_rd2  in  DATA_W each  register-file read data; combinational from rf_ra1/rf_ra2.
REQ-013 rf_we  out  1; rf_wa  out  ADDR_W; rf_wd  out  DATA_W  register-file write port.
REQ-014 add_a / add_b  out  DATA_W; add_cin  out  1  adder operands.
REQ-015 add_sum  in  DATA_W; add_cout  in  1  combinational adder result.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 result  out  DATA_W  last written-back value.
REQ-018 cout_flag  out  1  carry-out of the last completed operation.
REQ-019 op_count  out  16  count of completed operations.

Function
REQ-020 FSM states SHALL be IDLE, READ, EXEC and WB, with unconditional transitions READ->EXEC->WB->IDLE.
REQ-021 cmd_ready SHALL be 1 exactly when state==IDLE.
REQ-022 A handshake SHALL occur when cmd_valid&cmd_ready at a rising edge; op, rd, rs1, rs2 and imm are latched there and state goes IDLE->READ.
REQ-023 cmd_valid while not IDLE SHALL be ignored: no buffering, no side effects.
REQ-024 In READ, rf_ra1=rs1 and rf_ra2=rs2; rf_rd1 and rf_rd2 are captured into opA and opB at the end of READ.
REQ-025 In EXEC, the adder inputs SHALL be set per operation:
- ADD: a=opA, b=opB, cin=0.
- SUB: a=opA, b=~opB, cin=1.
- ADDI: a=opA, b=imm, cin=0.
- LDI: a=0, b=imm, cin=0.
REQ-026 At the end of EXEC, add_sum and add_cout SHALL be captured into a result register.
REQ-027 In EXEC, all other add_* inputs SHALL be 0.
REQ-028 In WB, rf_we=1, rf_wa=rd, rf_wd=captured sum and done=1, each for exactly one cycle.
REQ-029 At the end of WB, result and cout_flag SHALL update and op_count SHALL increment.
REQ-030 rf_we and done SHALL be 0 in every state except WB.
REQ-031 Latency: handshake at edge T gives rf_we/done high in cycle T+3 and cmd_ready high again in cycle T+4, for a throughput of one operation per 4 cycles.
REQ-032 Arithmetic SHALL be modulo 2^DATA_W, with overflow reported only via cout_flag; for SUB, cout_flag=1 means no borrow (opA>=opB unsigned).
REQ-033 Register 0 SHALL have no special treatment and SHALL be writable.
REQ-034 op_count SHALL wrap from 0xFFFF to 0x0000.
REQ-035 Back-to-back dependent commands SHALL see prior writeback, because READ of the next command is at least 2 cycles after WB.

Reset
REQ-036 On a wb_rst_i edge, state SHALL go to IDLE, and result, cout_flag, op_count, opA, opB and the latched command fields SHALL all become 0.
REQ-037 During reset, rf_we, done, rf_ra*, rf_wa, rf_wd and add_* SHALL be 0, and cmd_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-038 Reset asserted in READ, EXEC or WB SHALL abort the operation: no write occurs after that edge, no done pulse and no op_count increment.
REQ-039 Reset SHALL take priority over a simultaneous handshake, and the command SHALL be dropped.

Verification
REQ-040 LDI rd=3 imm=0x0000_0005 -> WB writes reg3=5; done pulses at T+3; result=5; cout_flag=0; op_count=1.
REQ-041 With reg1=0xFFFF_FFFF and reg2=1, ADD rd=4 rs1=1 rs2=2 -> rf_wd=0, cout_flag=1.
REQ-042 With reg1=3 and reg2=5, SUB rd=6 -> rf_wd=0xFFFF_FFFE, cout_flag=0; swapped operands -> 2, cout_flag=1.
REQ-043 cmd_valid held high continuously with 3 commands -> handshakes exactly 4 cycles apart; a dependent ADDI reads the updated register.
REQ-044 wb_rst_i pulsed in EXEC -> no rf_we, no done, op_count unchanged at 0, and cmd_ready=1 on the next cycle.
REQ-045 Force op_count to 0xFFFF (65535 LDIs or preload) and complete one more command -> op_count=0x0000.
